led_show_sequencer: RTL and testbench

Controller that generates the 3-bit `state` code consumed by the LED pattern block (S0..S5 patterns on LEDR[17:0]). It replaces free-running state selection with a timed sequencer: a clock prescaler produces a step tick, and each pattern state is held for a programmable number of ticks before the sequence advances. Front-panel start/pause/stop keys are synchronised and edge-detected, with direction selectable. Sits between the board keys/switches and the pattern block.

---
 rtl/led_show_sequencer_pkg.sv | 43 ++++
 rtl/led_show_sequencer_if.sv | 25 ++
 rtl/led_show_sequencer_key_edge_sync.sv | 28 ++
 rtl/led_show_sequencer.sv | 143 ++++++++++++++
 tb/tb_led_show_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_show_sequencer_pkg.sv
// Shared definitions for the LED show sequencer: pattern state codes,
// control FSM encoding and the modulo-6 stepping helpers.
package led_show_pkg;

   typedef logic [2:0] pattern_t;

   localparam pattern_t S0 = 3'd0;
   localparam pattern_t S1 = 3'd1;
   localparam pattern_t S2 = 3'd2;
   localparam pattern_t S3 = 3'd3;
   localparam pattern_t S4 = 3'd4;
   localparam pattern_t S5 = 3'd5;

   localparam int NUM_STATES = 6;

   typedef enum logic [1:0] {
      CTRL_IDLE   = 2'd0,
      CTRL_RUN    = 2'd1,
      CTRL_PAUSED = 2'd2
   } ctrl_e;

   // Next pattern code, using explicit end compares so 6 and 7 are never produced
   function automatic pattern_t step_pattern(input pattern_t cur, input logic down);
      pattern_t nxt;
      if (down) begin
         if (cur == S0) nxt = S5;
         else           nxt = cur - 3'd1;
      end else begin
         if (cur >= S5) nxt = S0;
         else           nxt = cur + 3'd1;
      end
      return nxt;
   endfunction

   // True when stepping from cur in the given direction crosses the sequence end
   function automatic logic crosses_end(input pattern_t cur, input logic down);
      logic hit;
      if (down) hit = (cur == S0);
      else      hit = (cur >= S5);
      return hit;
   endfunction

endpackage

// File: rtl/led_show_sequencer_if.sv
// Key inputs and pattern/status outputs of the LED show sequencer.
// master: board/keys side; slave: the sequencer itself.
interface led_show_sequencer_if;
   import led_show_pkg::*;

   logic     start;
   logic     pause;
   logic     stop;
   logic     dir;
   pattern_t state;
   logic     running;
   logic     frozen;
   logic     tick;
   logic     wrap;

   modport master (
      output start, pause, stop, dir,
      input  state, running, frozen, tick, wrap
   );

   modport slave (
      input  start, pause, stop, dir,
      output state, running, frozen, tick, wrap
   );
endinterface

// File: rtl/led_show_sequencer_key_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for a front-panel key.
// All flops reset high, so a key held through reset release produces no pulse
// until it has been seen low and pressed again.
module key_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic pulse
);
   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Synchronise the asynchronous key level and keep one cycle of history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
         prev_r <= 1'b1;
      end else begin
         meta_r <= key;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign pulse = sync_r & ~prev_r;
endmodule

// File: rtl/led_show_sequencer.sv
// Timed LED pattern sequencer: prescaler tick, per-state dwell counter and
// IDLE/RUN/PAUSED control driven by synchronised start/pause/stop key edges.
module led_show_sequencer
   import led_show_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int DWELL    = 4
) (
   input logic                 clk,
   input logic                 reset,
   led_show_sequencer_if.slave bus
);
   localparam int PW = (TICK_DIV > 32'sd1) ? $clog2(TICK_DIV) : 32'sd1;
   localparam int DW = (DWELL > 32'sd1) ? $clog2(DWELL) : 32'sd1;

   localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 32'sd1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(32'd1);
   localparam logic [PW-1:0] PRESC_ZERO = PW'(32'd0);
   localparam logic [DW-1:0] DWELL_MAX  = DW'(DWELL - 32'sd1);
   localparam logic [DW-1:0] DWELL_ONE  = DW'(32'd1);
   localparam logic [DW-1:0] DWELL_ZERO = DW'(32'd0);

   localparam logic [1:0] ST_IDLE   = CTRL_IDLE;
   localparam logic [1:0] ST_RUN    = CTRL_RUN;
   localparam logic [1:0] ST_PAUSED = CTRL_PAUSED;

   logic          start_ev_s, pause_ev_s, stop_ev_s;
   logic [1:0]    ctrl_r, ctrl_n_s;
   pattern_t      state_r, state_n_s, run_state_s;
   logic [PW-1:0] presc_r, presc_n_s, run_presc_s;
   logic [DW-1:0] dwell_r, dwell_n_s, run_dwell_s;
   logic          run_wrap_s, wrap_n_s;
   logic          running_r, frozen_r, tick_r, wrap_r;

   key_edge_sync u_start (.clk(clk), .reset(reset), .key(bus.start), .pulse(start_ev_s));
   key_edge_sync u_pause (.clk(clk), .reset(reset), .key(bus.pause), .pulse(pause_ev_s));
   key_edge_sync u_stop  (.clk(clk), .reset(reset), .key(bus.stop),  .pulse(stop_ev_s));

   // One RUN cycle of counting: prescaler, dwell on each tick, pattern step on the last dwell tick
   always_comb begin
      run_presc_s = presc_r;
      run_dwell_s = dwell_r;
      run_state_s = state_r;
      run_wrap_s  = 1'b0;
      if (presc_r == PRESC_MAX) begin
         run_presc_s = PRESC_ZERO;
         if (dwell_r == DWELL_MAX) begin
            run_dwell_s = DWELL_ZERO;
            // dir is a slow switch level read directly at the advance
            run_state_s = step_pattern(state_r, bus.dir);
            run_wrap_s  = crosses_end(state_r, bus.dir);
         end else begin
            run_dwell_s = dwell_r + DWELL_ONE;
         end
      end else begin
         run_presc_s = presc_r + PRESC_ONE;
      end
   end

   // Control FSM; stop outranks start, which outranks pause
   always_comb begin
      ctrl_n_s  = ctrl_r;
      state_n_s = state_r;
      presc_n_s = presc_r;
      dwell_n_s = dwell_r;
      wrap_n_s  = 1'b0;
      case (ctrl_r)
         ST_IDLE: begin
            if (start_ev_s) begin
               ctrl_n_s  = ST_RUN;
               state_n_s = S0;
               presc_n_s = PRESC_ZERO;
               dwell_n_s = DWELL_ZERO;
            end else begin
               ctrl_n_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop_ev_s) begin
               ctrl_n_s  = ST_IDLE;
               state_n_s = S0;
               presc_n_s = PRESC_ZERO;
               dwell_n_s = DWELL_ZERO;
            end else if (pause_ev_s && !start_ev_s) begin
               // counters hold so a later resume continues mid-dwell
               ctrl_n_s = ST_PAUSED;
            end else begin
               presc_n_s = run_presc_s;
               dwell_n_s = run_dwell_s;
               state_n_s = run_state_s;
               wrap_n_s  = run_wrap_s;
            end
         end
         ST_PAUSED: begin
            if (stop_ev_s) begin
               ctrl_n_s  = ST_IDLE;
               state_n_s = S0;
               presc_n_s = PRESC_ZERO;
               dwell_n_s = DWELL_ZERO;
            end else if (start_ev_s) begin
               ctrl_n_s = ST_RUN;
            end else begin
               ctrl_n_s = ST_PAUSED;
            end
         end
         default: begin
            ctrl_n_s  = ST_IDLE;
            state_n_s = S0;
            presc_n_s = PRESC_ZERO;
            dwell_n_s = DWELL_ZERO;
         end
      endcase
   end

   // State, counters and all outputs registered; tick marks cycles with the prescaler at its top in RUN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_r    <= ST_IDLE;
         state_r   <= S0;
         presc_r   <= PRESC_ZERO;
         dwell_r   <= DWELL_ZERO;
         running_r <= 1'b0;
         frozen_r  <= 1'b0;
         tick_r    <= 1'b0;
         wrap_r    <= 1'b0;
      end else begin
         ctrl_r    <= ctrl_n_s;
         state_r   <= state_n_s;
         presc_r   <= presc_n_s;
         dwell_r   <= dwell_n_s;
         running_r <= (ctrl_n_s == ST_RUN);
         frozen_r  <= (ctrl_n_s == ST_PAUSED);
         tick_r    <= (ctrl_n_s == ST_RUN) && (presc_n_s == PRESC_MAX);
         wrap_r    <= wrap_n_s;
      end
   end

   assign bus.state   = state_r;
   assign bus.running = running_r;
   assign bus.frozen  = frozen_r;
   assign bus.tick    = tick_r;
   assign bus.wrap    = wrap_r;
endmodule

// File: tb/tb_led_show_sequencer.sv
// Directed self-checking bench for led_show_sequencer with TICK_DIV=4, DWELL=2.
// Outputs are sampled on the falling clock edge as {state, running, frozen, tick, wrap}.
module tb_led_show_sequencer;
   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;
   logic [6:0] obs;

   led_show_sequencer_if bus ();

   led_show_sequencer #(.TICK_DIV(4), .DWELL(2)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   assign obs = {bus.state, bus.running, bus.frozen, bus.tick, bus.wrap};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse keys for one cycle; returns at the falling edge after the event takes effect
   task automatic press(input logic s, input logic p, input logic t);
      bus.start = s;
      bus.pause = p;
      bus.stop  = t;
      @(negedge clk);
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.stop  = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.stop  = 1'b0;
      bus.dir   = 1'b0;
      cyc(2);
      tests_run++;
      if (obs !== 7'd0) begin
         tests_failed++;
         $display("FAIL reset_hold: got %b expected %b", obs, 7'd0);
      end
      reset = 1'b1;
      cyc(4);
      tests_run++;
      if (obs !== 7'd0) begin
         tests_failed++;
         $display("FAIL reset_idle: got %b expected %b", obs, 7'd0);
      end
   endtask

   task automatic test_start_sequence();
      logic [6:0] exp;
      logic [2:0] st;
      bus.start = 1'b1;
      @(negedge clk);
      tests_run++;
      if (obs !== 7'd0) begin
         tests_failed++;
         $display("FAIL start_latency1: got %b expected %b", obs, 7'd0);
      end
      bus.start = 1'b0;
      @(negedge clk);
      tests_run++;
      if (obs !== 7'd0) begin
         tests_failed++;
         $display("FAIL start_latency2: got %b expected %b", obs, 7'd0);
      end
      @(negedge clk);
      exp = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL start_entry: got %b expected %b", obs, exp);
      end
      for (int j = 1; j <= 50; j++) begin
         @(negedge clk);
         st  = 3'((j / 8) % 6);
         exp = {st, 1'b1, 1'b0, (j % 4 == 3), (j == 48)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL start_seq j=%0d: got %b expected %b", j, obs, exp);
         end
      end
      press(1'b0, 1'b0, 1'b1);
      tests_run++;
      if (obs !== 7'd0) begin
         tests_failed++;
         $display("FAIL run_stop: got %b expected %b", obs, 7'd0);
      end
   endtask

   task automatic test_pause_resume();
      logic [6:0] exp;
      press(1'b1, 1'b0, 1'b0);
      cyc(17);
      press(1'b0, 1'b1, 1'b0);
      exp = {3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int h = 0; h <= 20; h++) begin
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL pause_hold h=%0d: got %b expected %b", h, obs, exp);
         end
         @(negedge clk);
      end
      press(1'b1, 1'b0, 1'b0);
      exp = {3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL resume_entry: got %b expected %b", obs, exp);
      end
      for (int r = 1; r <= 5; r++) begin
         @(negedge clk);
         exp = {((r < 5) ? 3'd2 : 3'd3), 1'b1, 1'b0, (r == 4), 1'b0};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL resume_remaining r=%0d: got %b expected %b", r, obs, exp);
         end
      end
      press(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_direction();
      logic [6:0] exp;
      logic [2:0] st;
      bus.dir = 1'b1;
      press(1'b1, 1'b0, 1'b0);
      for (int j = 1; j <= 24; j++) begin
         if (j == 22) bus.dir = 1'b0;
         @(negedge clk);
         if (j < 8)       st = 3'd0;
         else if (j < 16) st = 3'd5;
         else if (j < 24) st = 3'd4;
         else             st = 3'd5;
         exp = {st, 1'b1, 1'b0, (j % 4 == 3), (j == 8)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL dir_seq j=%0d: got %b expected %b", j, obs, exp);
         end
      end
      press(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_same_cycle();
      logic [6:0] exp;
      press(1'b1, 1'b1, 1'b0);
      exp = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL idle_start_pause: got %b expected %b", obs, exp);
      end
      cyc(9);
      press(1'b1, 1'b1, 1'b0);
      exp = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL run_start_pause: got %b expected %b", obs, exp);
      end
      press(1'b1, 1'b0, 1'b1);
      tests_run++;
      if (obs !== 7'd0) begin
         tests_failed++;
         $display("FAIL run_stop_start: got %b expected %b", obs, 7'd0);
      end
   endtask

   task automatic test_stop_paused();
      logic [6:0] exp;
      press(1'b1, 1'b0, 1'b0);
      cyc(10);
      press(1'b0, 1'b1, 1'b0);
      exp = {3'd1, 1'b0, 1'b1, 1'b0, 1'b0};
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL paused_s1: got %b expected %b", obs, exp);
      end
      press(1'b0, 1'b0, 1'b1);
      tests_run++;
      if (obs !== 7'd0) begin
         tests_failed++;
         $display("FAIL paused_stop: got %b expected %b", obs, 7'd0);
      end
      press(1'b1, 1'b0, 1'b0);
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         exp = {((j < 8) ? 3'd0 : 3'd1), 1'b1, 1'b0, (j % 4 == 3), 1'b0};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL restart_full_dwell j=%0d: got %b expected %b", j, obs, exp);
         end
      end
      press(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_in_run();
      logic [6:0] exp;
      press(1'b1, 1'b0, 1'b0);
      cyc(32);
      exp = {3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL pre_reset_s4: got %b expected %b", obs, exp);
      end
      bus.start = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if (obs !== 7'd0) begin
         tests_failed++;
         $display("FAIL async_reset: got %b expected %b", obs, 7'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== 7'd0) begin
            tests_failed++;
            $display("FAIL held_start k=%0d: got %b expected %b", k, obs, 7'd0);
         end
      end
      bus.start = 1'b0;
      cyc(3);
      press(1'b1, 1'b0, 1'b0);
      exp = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL repress_start: got %b expected %b", obs, exp);
      end
      press(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_start_sequence();
      test_pause_resume();
      test_direction();
      test_same_cycle();
      test_stop_paused();
      test_reset_in_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
